// File: rtl/truth_table_scanner_pkg.sv
// Shared types and constants for the truth-table scanner and its helpers.
package truth_table_scanner_pkg;

   localparam int ROWS  = 8;
   localparam int ROW_W = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } tts_state_t;

endpackage

// File: rtl/truth_table_scanner_mismatch_finder.sv
// Compares a captured truth table against a golden one and reports the lowest differing row.
module tt_mismatch_finder
   import truth_table_scanner_pkg::*;
(
   input  logic [ROWS-1:0]  captured,
   input  logic [ROWS-1:0]  golden,
   output logic             match,
   output logic [ROW_W-1:0] idx
);

   logic [ROWS-1:0] diff;

   assign diff  = captured ^ golden;
   assign match = (diff == '0);

   // Scan from the top row down so the lowest differing row wins.
   always_comb begin
      idx = '0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (diff[i]) idx = ROW_W'(i);
      end
   end

endmodule

// File: rtl/truth_table_scanner.sv
// Walks x through all eight input rows of a 3-input circuit, captures f per row and checks it.
module truth_table_scanner
   import truth_table_scanner_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             start,
   input  logic             abort,
   input  logic [ROWS-1:0]  expected,
   input  logic             f,
   output logic [ROW_W-1:0] x,
   output logic             busy,
   output logic             done,
   output logic [ROWS-1:0]  table_out,
   output logic             match,
   output logic [ROW_W-1:0] mismatch_idx
);

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(ROWS - 1);

   tts_state_t       state;
   logic [ROW_W-1:0] row;
   logic [3:0]       settle_cnt;
   logic [ROWS-1:0]  work;
   logic [ROWS-1:0]  exp_lat;
   logic [ROWS-1:0]  work_next;
   logic             fm_match;
   logic [ROW_W-1:0] fm_idx;

   // Working table with the current row's sample folded in, so the final row is
   // visible to the comparator on the same edge that enters DONE.
   always_comb begin
      work_next      = work;
      work_next[row] = f;
   end

   tt_mismatch_finder u_finder (
      .captured (work_next),
      .golden   (exp_lat),
      .match    (fm_match),
      .idx      (fm_idx)
   );

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state        <= IDLE;
         row          <= '0;
         settle_cnt   <= '0;
         work         <= '0;
         exp_lat      <= '0;
         x            <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         table_out    <= '0;
         match        <= 1'b0;
         mismatch_idx <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  exp_lat    <= expected;
                  row        <= '0;
                  settle_cnt <= '0;
                  work       <= '0;
                  x          <= '0;
                  busy       <= 1'b1;
                  state      <= SETTLE;
               end
            end
            SETTLE: begin
               if (abort) begin
                  x     <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (settle_cnt == SETTLE_LAST) begin
                  settle_cnt <= '0;
                  state      <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            SAMPLE: begin
               if (abort) begin
                  x     <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  work <= work_next;
                  if (row == LAST_ROW) begin
                     x            <= '0;
                     busy         <= 1'b0;
                     done         <= 1'b1;
                     table_out    <= work_next;
                     match        <= fm_match;
                     mismatch_idx <= fm_idx;
                     state        <= DONE;
                  end else begin
                     row   <= row + 3'd1;
                     x     <= row + 3'd1;
                     state <= SETTLE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench: circuit f = (~x3 & x2) | (x3 & x1) (table 8'hAC) scanned by two scanner instances.
module tb_truth_table_scanner;

   logic       clk = 1'b0;
   logic       aresetn;
   logic       start, abort, start4, abort4, noise4;
   logic [7:0] expected, expected4;
   logic [2:0] x, x4, mismatch_idx, mismatch_idx4;
   logic       f, f4, busy, busy4, done, done4, match, match4;
   logic [7:0] table_out, table_out4;

   int nvec  = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   assign f  = (~x[2] & x[1]) | (x[2] & x[0]);
   assign f4 = ((~x4[2] & x4[1]) | (x4[2] & x4[0])) ^ noise4;

   truth_table_scanner #(.SETTLE_CYCLES(1)) dut (
      .clk (clk), .aresetn (aresetn), .start (start), .abort (abort),
      .expected (expected), .f (f), .x (x), .busy (busy), .done (done),
      .table_out (table_out), .match (match), .mismatch_idx (mismatch_idx)
   );

   truth_table_scanner #(.SETTLE_CYCLES(4)) dut4 (
      .clk (clk), .aresetn (aresetn), .start (start4), .abort (abort4),
      .expected (expected4), .f (f4), .x (x4), .busy (busy4), .done (done4),
      .table_out (table_out4), .match (match4), .mismatch_idx (mismatch_idx4)
   );

   typedef struct {
      logic [7:0] golden;
      logic [7:0] tbl;
      logic       m;
      logic [2:0] idx;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      nvec++;
      if (act !== req) begin
         nfail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start a scan with SETTLE_CYCLES=1 and step 16 edges; flags any cycle where
   // x, busy or done deviate from the two-cycles-per-row walk.
   task automatic run_scan(input logic [7:0] golden, input bit poke_start, output logic seq_bad);
      expected = golden;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      seq_bad  = 1'b0;
      for (int c = 0; c < 16; c++) begin
         if (x !== 3'(c / 2) || busy !== 1'b1 || done !== 1'b0) seq_bad = 1'b1;
         if (poke_start && c == 5) start = 1'b1;
         if (poke_start && c == 6) start = 1'b0;
         tick();
      end
   endtask

   initial begin
      vec_t vecs[6];
      logic bad;
      logic seen;

      vecs[0] = '{golden: 8'hAC, tbl: 8'hAC, m: 1'b1, idx: 3'd0};
      vecs[1] = '{golden: 8'hAD, tbl: 8'hAC, m: 1'b0, idx: 3'd0};
      vecs[2] = '{golden: 8'h2C, tbl: 8'hAC, m: 1'b0, idx: 3'd7};
      vecs[3] = '{golden: 8'hAE, tbl: 8'hAC, m: 1'b0, idx: 3'd1};
      vecs[4] = '{golden: 8'h00, tbl: 8'hAC, m: 1'b0, idx: 3'd2};
      vecs[5] = '{golden: 8'hAC, tbl: 8'hAC, m: 1'b1, idx: 3'd0};

      aresetn = 1'b0; start = 1'b0; abort = 1'b0; expected = 8'h00;
      start4 = 1'b0; abort4 = 1'b0; expected4 = 8'hAC; noise4 = 1'b0;
      #12;
      chk("rst_x", x, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_table", table_out, 0);
      chk("rst_match", match, 0);
      chk("rst_idx", mismatch_idx, 0);
      @(negedge clk);
      aresetn = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_scan(vecs[i].golden, (i == 2), bad);
         chk("scan_seq", bad, 0);
         chk("done_at_16", done, 1);
         chk("busy_in_done", busy, 0);
         chk("table_out", table_out, vecs[i].tbl);
         chk("match", match, vecs[i].m);
         chk("mismatch_idx", mismatch_idx, vecs[i].idx);
         if (i == 2) start = 1'b1;
         tick();
         start = 1'b0;
         chk("done_pulse", done, 0);
         tick();
         chk("no_queued_start", busy, 0);
      end

      // Abort mid-scan at row 3: results of the previous AC scan must survive.
      expected = 8'h00;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      chk("abort_x_before", x, 3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_x", x, 0);
      chk("abort_done", done, 0);
      chk("abort_table", table_out, 8'hAC);
      chk("abort_match", match, 1);
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
         tick();
      end
      chk("abort_stays_idle", seen, 0);

      // Start and abort together in IDLE.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("collide_busy", busy, 0);
      tick();
      chk("collide_busy2", busy, 0);
      chk("collide_done", done, 0);

      // Asynchronous reset between edges while x=5.
      expected = 8'hAC;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      chk("pre_reset_x", x, 5);
      #2;
      aresetn = 1'b0;
      #1;
      chk("async_x", x, 0);
      chk("async_busy", busy, 0);
      chk("async_done", done, 0);
      chk("async_table", table_out, 0);
      chk("async_match", match, 0);
      chk("async_idx", mismatch_idx, 0);
      @(negedge clk);
      aresetn = 1'b1;
      run_scan(8'hAC, 1'b0, bad);
      chk("post_reset_seq", bad, 0);
      chk("post_reset_done", done, 1);
      chk("post_reset_table", table_out, 8'hAC);
      chk("post_reset_match", match, 1);
      tick();

      // SETTLE_CYCLES=4 with f disturbed during SETTLE cycles only.
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      bad = 1'b0;
      for (int c = 0; c < 40; c++) begin
         noise4 = ((c % 5) != 4) && ((c % 2) == 0);
         if (x4 !== 3'(c / 5) || busy4 !== 1'b1 || done4 !== 1'b0) bad = 1'b1;
         tick();
      end
      noise4 = 1'b0;
      chk("s4_seq", bad, 0);
      chk("s4_done_at_40", done4, 1);
      chk("s4_table", table_out4, 8'hAC);
      chk("s4_match", match4, 1);
      chk("s4_idx", mismatch_idx4, 0);
      tick();
      chk("s4_done_pulse", done4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
